// File: rtl/posit_encode_pipe_pkg.sv
// Shared widths, operation codes and posit constants for the posit encode pipeline.
// The widths are derived from the posit width N and the exponent width ES.
package posit_encode_pipe_pkg;

    localparam int POSIT_N  = 16;
    localparam int POSIT_ES = 1;
    localparam int MAX_N    = 64;

    // Significand width including the hidden bit.
    function automatic int mant_size(input int n, input int es);
        return n - es - 2;
    endfunction

    function automatic int te_size(input int n, input int es);
        return es + $clog2(n) + 3;
    endfunction

    function automatic int frac_full_size(input int n, input int es);
        return 2 * mant_size(n, es);
    endfunction

    localparam int MANT_SIZE      = mant_size(POSIT_N, POSIT_ES);
    localparam int TE_SIZE        = te_size(POSIT_N, POSIT_ES);
    localparam int FRAC_FULL_SIZE = frac_full_size(POSIT_N, POSIT_ES);

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } posit_op_e;

    // The constant helpers return MAX_N bits; callers keep the low n bits.
    function automatic logic [MAX_N-1:0] posit_zero(input int n);
        logic [MAX_N-1:0] v;
        v = {MAX_N{1'b0}};
        return v;
    endfunction

    function automatic logic [MAX_N-1:0] posit_nar(input int n);
        logic [MAX_N-1:0] v;
        v = {MAX_N{1'b0}};
        v[n-1] = 1'b1;
        return v;
    endfunction

    function automatic logic [MAX_N-1:0] posit_maxpos(input int n);
        logic [MAX_N-1:0] v;
        v = {MAX_N{1'b0}};
        for (int i = 0; i < n - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_N-1:0] posit_minpos(input int n);
        logic [MAX_N-1:0] v;
        v = {MAX_N{1'b0}};
        v[0] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/posit_round_encode.sv
// Combinational posit packer: regime build, guard/sticky extraction, RNE,
// saturation clamp, special cases and two's-complement negation.
module posit_round_encode
    import posit_encode_pipe_pkg::*;
#(
    parameter int N      = POSIT_N,
    parameter int ES     = POSIT_ES,
    parameter int KW     = te_size(N, ES) - ES,
    parameter int FRAC_W = frac_full_size(N, ES)
) (
    input  logic              sign,
    input  logic              is_zero,
    input  logic              is_nar,
    input  logic              sat_hi,
    input  logic              sat_lo,
    input  logic [KW-1:0]     k,
    input  logic [ES-1:0]     e,
    input  logic [FRAC_W-1:0] frac,
    output logic [N-1:0]      posit
);

    localparam int SW = 2 + ES + FRAC_W + N;
    localparam logic [MAX_N-1:0] ZERO_C   = posit_zero(N);
    localparam logic [MAX_N-1:0] NAR_C    = posit_nar(N);
    localparam logic [MAX_N-1:0] MAXPOS_C = posit_maxpos(N);
    localparam logic [MAX_N-1:0] MINPOS_C = posit_minpos(N);

    logic          k_neg_s;
    logic [KW-1:0] k_mag_s;
    logic [SW-1:0] seed_s;
    logic [SW-1:0] stream_s;
    logic [N-2:0]  body_s;
    logic          guard_s;
    logic          sticky_s;
    logic          round_up_s;
    logic [N-2:0]  body_rnd_s;
    logic [N-1:0]  mag_s;

    // The seed's top bit is replicated by the arithmetic shift: ones then a 0
    // for k >= 0, zeros then a 1 for k < 0. ~k equals -k-1 for negative k.
    // The zero padding keeps every shifted-out bit visible to sticky.
    assign k_neg_s  = k[KW-1];
    assign k_mag_s  = k_neg_s ? ~k : k;
    assign seed_s   = {~k_neg_s, k_neg_s, e, frac, {N{1'b0}}};
    assign stream_s = $signed(seed_s) >>> k_mag_s;

    assign body_s     = stream_s[SW-1 -: N-1];
    assign guard_s    = stream_s[SW-N];
    assign sticky_s   = |stream_s[SW-N-1:0];
    assign round_up_s = guard_s & (body_s[0] | sticky_s) & ~(&body_s);
    assign body_rnd_s = body_s + {{(N-2){1'b0}}, round_up_s};

    // Special-case priority, clamp and sign application.
    always_comb begin
        posit = ZERO_C[N-1:0];
        mag_s = ZERO_C[N-1:0];
        if (is_nar) begin
            posit = NAR_C[N-1:0];
        end else if (is_zero) begin
            posit = ZERO_C[N-1:0];
        end else begin
            if (sat_hi) begin
                mag_s = MAXPOS_C[N-1:0];
            end else if (sat_lo) begin
                mag_s = MINPOS_C[N-1:0];
            end else begin
                mag_s = {1'b0, body_rnd_s};
            end
            if (sign) begin
                posit = ~mag_s + {{(N-1){1'b0}}, 1'b1};
            end else begin
                posit = mag_s;
            end
        end
    end

endmodule

// File: rtl/posit_encode_pipe.sv
// Two-stage valid/ready pipeline that turns (sign, total exponent, fraction)
// into an N-bit posit; stage 1 splits the exponent, stage 2 packs and rounds.
module posit_encode_pipe
    import posit_encode_pipe_pkg::*;
#(
    parameter int  N      = POSIT_N,
    parameter int  ES     = POSIT_ES,
    localparam int TE_W   = te_size(N, ES),
    localparam int FRAC_W = frac_full_size(N, ES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [TE_W-1:0]   in_te,
    input  logic [FRAC_W-1:0] in_frac_full,
    input  logic              in_is_zero,
    input  logic              in_is_nar,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      out_posit
);

    localparam int KW = TE_W - ES;
    localparam logic signed [KW-1:0] K_HI = KW'(N - 2);
    localparam logic signed [KW-1:0] K_LO = KW'(-(N - 1));

    logic              s1_valid_r;
    logic              s1_sign_r;
    logic              s1_zero_r;
    logic              s1_nar_r;
    logic              s1_sat_hi_r;
    logic              s1_sat_lo_r;
    logic [KW-1:0]     s1_k_r;
    logic [ES-1:0]     s1_e_r;
    logic [FRAC_W-1:0] s1_frac_r;
    logic              s2_valid_r;
    logic [N-1:0]      out_posit_r;

    logic              s2_can_load_s;
    logic [KW-1:0]     k_s;
    logic [ES-1:0]     e_s;
    logic              sat_hi_s;
    logic              sat_lo_s;
    logic [N-1:0]      enc_posit_s;

    assign s2_can_load_s = ~s2_valid_r | out_ready;
    assign in_ready      = ~s1_valid_r | s2_can_load_s;
    assign out_valid     = s2_valid_r;
    assign out_posit     = out_posit_r;

    // te >>> ES is just the upper bits of te; the low ES bits are e.
    assign k_s      = in_te[TE_W-1:ES];
    assign e_s      = in_te[ES-1:0];
    assign sat_hi_s = ($signed(k_s) >= K_HI);
    assign sat_lo_s = ($signed(k_s) <= K_LO);

    // Stage 1 register: exponent split and saturation decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sign_r   <= 1'b0;
            s1_zero_r   <= 1'b0;
            s1_nar_r    <= 1'b0;
            s1_sat_hi_r <= 1'b0;
            s1_sat_lo_r <= 1'b0;
            s1_k_r      <= {KW{1'b0}};
            s1_e_r      <= {ES{1'b0}};
            s1_frac_r   <= {FRAC_W{1'b0}};
        end else begin
            if (in_ready) begin
                s1_valid_r <= in_valid;
            end
            if (in_valid && in_ready) begin
                s1_sign_r   <= in_sign;
                s1_zero_r   <= in_is_zero;
                s1_nar_r    <= in_is_nar;
                s1_sat_hi_r <= sat_hi_s;
                s1_sat_lo_r <= sat_lo_s;
                s1_k_r      <= k_s;
                s1_e_r      <= e_s;
                s1_frac_r   <= in_frac_full;
            end
        end
    end

    posit_round_encode #(
        .N      (N),
        .ES     (ES),
        .KW     (KW),
        .FRAC_W (FRAC_W)
    ) u_round_encode (
        .sign    (s1_sign_r),
        .is_zero (s1_zero_r),
        .is_nar  (s1_nar_r),
        .sat_hi  (s1_sat_hi_r),
        .sat_lo  (s1_sat_lo_r),
        .k       (s1_k_r),
        .e       (s1_e_r),
        .frac    (s1_frac_r),
        .posit   (enc_posit_s)
    );

    // Stage 2 register: output holds its value while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r  <= 1'b0;
            out_posit_r <= {N{1'b0}};
        end else if (s2_can_load_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                out_posit_r <= enc_posit_s;
            end
        end
    end

endmodule

// File: doc/posit_encode_pipe.md
Name: posit_encode_pipe

Overview:
Downstream neighbour of the arithmetic core. Takes the (sign, total exponent, full fraction) result of an ADD/SUB/MUL/DIV and produces the final N-bit posit: regime/exponent split, round-to-nearest-even, saturation, and two's-complement negation. It is a 2-stage pipeline with valid/ready handshakes on both sides, so the PPU can stall on output back-pressure.

Parameters:
N, 16, posit width in bits
ES, 1, exponent field width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_sign  input  1  result sign from sign decisor
in_te  input  TE_SIZE  signed total exponent, te = k*2^ES + e
in_frac_full  input  FRAC_FULL_SIZE  fraction, hidden bit removed; MSB has weight 2^-1
in_is_zero  input  1  upstream special case: result is zero
in_is_nar  input  1  upstream special case: result is NaR
out_valid  output  1  out_posit valid
out_ready  input  1  downstream accepts this cycle
out_posit  output  N  encoded posit

Behaviour:
- Reset (async, rst=1): both stage-valid flags cleared; out_valid=0, out_posit=0, in_ready=1 on the first cycle after release. Reset mid-flight discards all in-flight beats with no partial output.
- Handshake: a beat transfers on in_valid&in_ready or on out_valid&out_ready.
  - Stage 2 loads when it is empty or out_ready=1.
  - Stage 1 loads when stage 1 is empty or stage 1 advances into stage 2.
  - in_ready = !s1_valid | s2_can_load. It is combinational from out_ready and has no dependence on in_valid.
- Latency: 2 cycles from input acceptance to out_valid. Throughput: 1 beat/cycle with out_ready=1. Order is preserved. Capacity is 2 beats.
- While out_valid=1 and out_ready=0, out_posit is held stable.
- Stage 1 (registered): captures sign, zero/NaR flags and frac, and computes:
  - k = in_te >>> ES (arithmetic shift), e = in_te[ES-1:0].
  - Saturation flags: sat_hi = (k >= N-2), sat_lo = (k <= -(N-1)).
- Stage 2 (registered output):
  - Bitstream:
    - Regime is (k+1) ones followed by a 0 for k>=0, or -k zeros followed by a 1 for k<0.
    - Build the bitstream {regime, e, frac} and take its top N-1 bits as body.
    - guard = next bit; sticky = OR of all remaining bits.
  - RNE: body += guard & (body[0] | sticky). Do not round when body is all ones, so no overflow into NaR.
  - Clamp: sat_hi gives body = all ones (maxpos); sat_lo gives body = 0…01 (minpos). A normal result never rounds to zero.
  - Result: {1'b0, body}, two's-complemented when sign=1.
- Special-case priority: NaR (1 followed by N-1 zeros) > zero (all 0) > saturation > normal. For specials, sign is ignored.
- Simultaneous in/out transfer with both stages full: all stages shift in the same cycle, no bubble.

Decomposition:
- Shared package holds TE_SIZE, FRAC_FULL_SIZE, MANT_SIZE, op encodings, and posit constants POSIT_ZERO, POSIT_NAR, POSIT_MAXPOS, POSIT_MINPOS as functions of N/ES.
- One combinational sub-module, posit_round_encode, instantiated in stage 2. It implements regime build, guard/sticky, RNE, clamp and negation, which keeps the pipeline/handshake logic separate.

Test Plan:
(All values for N=16, ES=1.)
- te=0, frac=0, sign=0 → 0x4000. Same with sign=1 → 0xC000. te=1, frac=0 → 0x5000. Each appears 2 cycles after acceptance.
- Rounding at te=0 (12 body fraction bits):
  - frac with only the guard bit (bit 13 from MSB) set → tie with even LSB → 0x4000.
  - guard + any lower bit → 0x4001.
  - frac = 0x001/12 LSB set with guard set → round up to 0x4002.
- Saturation:
  - te=+100 → 0x7FFF; te=+100 with sign=1 → 0x8001.
  - te=-100 → 0x0001.
  - te=28 (k=14) with frac all ones → 0x7FFF, never 0x8000.
- Specials: in_is_nar=1 (any te/sign) → 0x8000; in_is_zero=1 → 0x0000; both set → 0x8000.
- Back-pressure:
  - Stream 4 beats with in_valid=1 and out_ready=0 for 4 cycles → in_ready falls after 2 accepted.
  - out_posit is held stable.
  - Raising out_ready drains all 4 beats in order, one per cycle, with none lost or duplicated.
- Reset: assert rst asynchronously (mid-cycle) with 2 beats in flight → out_valid=0 immediately. After release, out_valid stays 0 until new input arrives, and the first output corresponds to the first post-reset beat.
